// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// State encodings, header/word byte counts and stream widths.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned COUNT_W        = HDR_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid_c pulses
// combinationally with the byte that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                push,
    input  logic [BYTE_W-1:0]   push_byte,
    output logic                word_valid_c,
    output logic [WORD_W-1:0]   word_c
);

    localparam int unsigned SH_W = WORD_W - BYTE_W;

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;

    // Older bytes shift toward bit 0 so the first byte lands in [7:0].
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (push) begin
            cnt_d = cnt_q + BCNT_W'(1);
            sh_d  = {push_byte, sh_q[SH_W-1:BYTE_W]};
        end
    end

    always_comb begin
        word_valid_c = push && !clr && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
        word_c       = {push_byte, sh_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count + little-endian words into instruction memory,
// holding the core in reset until done. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   in_byte,
    input  logic                reload,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_waddr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                error
);

    localparam int unsigned CMP_W = COUNT_W + 1;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_END = ST_CSUM;
`else
    localparam state_e ST_END = ST_DONE;
`endif

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]    imem_waddr_q, imem_waddr_d;
    logic [WORD_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]    csum_q, csum_d;
`endif

    logic                 fire_c;
    logic                 restart_c;
    logic                 last_word_c;
    logic [COUNT_W-1:0]   hdr_count_c;
    logic                 word_valid_c;
    logic [WORD_W-1:0]    word_c;

    always_comb begin
        in_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                   (state_q == ST_DATA) || (state_q == ST_CSUM);
        fire_c      = in_valid && in_ready;
        hdr_count_c = {in_byte, count_q[BYTE_W-1:0]};
        last_word_c = (CMP_W'(addr_q) + CMP_W'(1)) == CMP_W'(count_q);
    end

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (restart_c),
        .push         (fire_c && (state_q == ST_DATA)),
        .push_byte    (in_byte),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state, address/count tracking and registered write port.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        restart_c    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            ST_HDR0: begin
                if (fire_c) begin
                    count_d = COUNT_W'(in_byte);
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (fire_c) begin
                    count_d = hdr_count_c;
                    if (hdr_count_c == '0) begin
                        state_d = ST_END;
                    end else if (CMP_W'(hdr_count_c) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_byte;
`endif
                    if (word_valid_c) begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = addr_q;
                        imem_wdata_d = word_c;
                        addr_d       = addr_q + ADDR_W'(1);
                        if (last_word_c) begin
                            state_d = ST_END;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (fire_c) begin
                    state_d = (in_byte == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d   = ST_HDR0;
                    addr_d    = '0;
                    restart_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            default: state_d = ST_HDR0;
        endcase
        // cpu_rst lags state by one cycle so the final write lands first.
        cpu_rst_d = (state_q != ST_DONE);
        done_d    = (state_d == ST_DONE);
        error_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR0;
            addr_q       <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams images, compares the observed
// write log and handshake/status timing against an image-level model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [ADDR_W+31:0] wlog[$];
    logic [31:0]        ws[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && imem_we) wlog.push_back({imem_waddr, imem_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] csum_of();
        logic [7:0] x;
        x = 8'h00;
        foreach (ws[i]) x = x ^ ws[i][7:0] ^ ws[i][15:8] ^ ws[i][23:16] ^ ws[i][31:24];
        return x;
    endfunction

    // Called at #1 after a clock edge; returns at #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit bubbles);
        if (bubbles) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        check("in_ready_load", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    // Streams an image of ws with header count n and compares against the model.
    task automatic load_image(input int unsigned n, input logic [7:0] csum, input bit bubbles);
        bit          bad;
        bit          ok;
        int unsigned exp_wr;
        wlog.delete();
        bad = n > (32'd1 << ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ok = !bad && (csum == csum_of());
`else
        ok = !bad;
`endif
        exp_wr = bad ? 0 : n;
        send_byte(n[7:0], bubbles);
        send_byte(n[15:8], bubbles);
        if (!bad) begin
            for (int i = 0; i < int'(n); i++)
                for (int b = 0; b < 4; b++)
                    send_byte(ws[i][8*b +: 8], bubbles);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(csum, bubbles);
`else
            check("last_word_we", 64'(imem_we), 64'(n > 0));
`endif
        end
        check("end_done", 64'(done), 64'(ok));
        check("end_error", 64'(error), 64'(!ok));
        check("end_ready", 64'(in_ready), 64'(0));
        check("end_cpu_rst_hold", 64'(cpu_rst), 64'(1));
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        @(posedge clk); #1;
        check("cpu_rst_next", 64'(cpu_rst), 64'(!ok));
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("trail_ready", 64'(in_ready), 64'(0));
        check("trail_done", 64'(done), 64'(ok));
        check("trail_cpu_rst", 64'(cpu_rst), 64'(!ok));
        check("wr_count", 64'(wlog.size()), 64'(exp_wr));
        for (int i = 0; i < int'(exp_wr) && i < wlog.size(); i++) begin
            check("wr_addr", 64'(wlog[i][ADDR_W+31:32]), 64'(i[ADDR_W-1:0]));
            check("wr_data", 64'(wlog[i][31:0]), 64'(ws[i]));
        end
    endtask

    task automatic do_reload();
        bit was_done;
        was_done = done;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("rl_done", 64'(done), 64'(0));
        check("rl_error", 64'(error), 64'(0));
        check("rl_ready", 64'(in_ready), 64'(1));
        check("rl_cpu_rst_j", 64'(cpu_rst), 64'(!was_done));
        @(posedge clk); #1;
        check("rl_cpu_rst_j1", 64'(cpu_rst), 64'(1));
    endtask

    task automatic random_words(input int unsigned n);
        ws.delete();
        for (int i = 0; i < int'(n); i++) ws.push_back($urandom);
    endtask

    initial begin
        int unsigned n;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_we", 64'(imem_we), 64'(0));
        check("rst_waddr", 64'(imem_waddr), 64'(0));
        check("rst_wdata", 64'(imem_wdata), 64'(0));
        check("rst_cpu_rst", 64'(cpu_rst), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        ws = {32'h00100513, 32'h00B505B3};
        load_image(2, csum_of(), 1'b0);

        do_reload();
        ws.delete();
        load_image(0, 8'h00, 1'b0);

        do_reload();
        ws.delete();
        load_image(257, 8'h00, 1'b0);

        do_reload();
        ws = {32'hDEADBEEF};
        load_image(1, csum_of(), 1'b1);

        // Async reset in the middle of a word; the partial image is dropped.
        do_reload();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_cpu_rst", 64'(cpu_rst), 64'(1));
        check("mid_rst_ready", 64'(in_ready), 64'(1));
        check("mid_rst_we", 64'(imem_we), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ws = {32'h11223344};
        load_image(1, csum_of(), 1'b0);

        for (int t = 0; t < 4; t++) begin
            do_reload();
            n = $urandom_range(6, 1);
            random_words(n);
            load_image(n, csum_of(), 1'b1);
        end

        do_reload();
        random_words(32'd1 << ADDR_W);
        load_image(32'd1 << ADDR_W, csum_of(), 1'b0);

        do_reload();
        ws = {32'h04030201};
        load_image(1, 8'h04, 1'b0);
        do_reload();
        load_image(1, 8'h05, 1'b1);
        do_reload();
        random_words(3);
        load_image(3, csum_of(), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
